// File: rtl/svm_axil_pkg.sv
// Shared types and constants for the SVM AXI4-Lite master.
package svm_axil_pkg;

    // Transaction FSM states; a read's AR phase lives inside RDATA_WAIT.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        WRESP      = 2'd2,
        RDATA_WAIT = 2'd3
    } axil_state_t;

    // AXI response codes passed back to the command side untouched.
    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    // Unprivileged, secure, data access.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/svm_axil_master.sv
// AXI4-Lite initiator: turns single-beat commands into complete AXI4-Lite
// write/read transactions, one at a time, and reports the result on a
// one-cycle response strobe. Every handshake-facing output is a flop.
module svm_axil_master
    import svm_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,

    output logic                    rsp_valid,
    output logic [1:0]              rsp_resp,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy,

    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    axil_state_t state, state_n;

    // AW and W may finish in different cycles; remember which one is done.
    logic aw_done, aw_done_n;
    logic w_done,  w_done_n;

    logic                  awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic [ADDR_WIDTH-1:0] awaddr_n, araddr_n;
    logic [DATA_WIDTH-1:0] wdata_n, rsp_rdata_n;
    logic [1:0]            rsp_resp_n;
    logic                  rsp_valid_n;

    logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Full-word writes only, and a fixed protection attribute.
    assign m_axi_wstrb  = '1;
    assign m_axi_awprot = AXI_PROT_DEFAULT;
    assign m_axi_arprot = AXI_PROT_DEFAULT;

    // Handshakes are judged on the registered valids/readies.
    assign accept = cmd_valid && cmd_ready;
    assign aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_hs   = m_axi_wvalid  && m_axi_wready;
    assign b_hs   = m_axi_bvalid  && m_axi_bready;
    assign ar_hs  = m_axi_arvalid && m_axi_arready;
    assign r_hs   = m_axi_rvalid  && m_axi_rready;

    // Next-state and next-output decode; each field holds unless its phase moves it.
    always_comb begin
        state_n     = state;
        aw_done_n   = aw_done;
        w_done_n    = w_done;
        awvalid_n   = m_axi_awvalid;
        wvalid_n    = m_axi_wvalid;
        bready_n    = m_axi_bready;
        arvalid_n   = m_axi_arvalid;
        rready_n    = m_axi_rready;
        awaddr_n    = m_axi_awaddr;
        araddr_n    = m_axi_araddr;
        wdata_n     = m_axi_wdata;
        rsp_resp_n  = rsp_resp;
        rsp_rdata_n = rsp_rdata;
        rsp_valid_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_write) begin
                        awaddr_n  = cmd_addr;
                        wdata_n   = cmd_wdata;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                        state_n   = WRITE;
                    end else begin
                        araddr_n  = cmd_addr;
                        arvalid_n = 1'b1;
                        state_n   = RDATA_WAIT;
                    end
                end
            end

            WRITE: begin
                if (aw_hs) awvalid_n = 1'b0;
                if (w_hs)  wvalid_n  = 1'b0;
                aw_done_n = aw_done || aw_hs;
                w_done_n  = w_done  || w_hs;
                if (aw_done_n && w_done_n) begin
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    bready_n  = 1'b1;
                    state_n   = WRESP;
                end
            end

            WRESP: begin
                if (b_hs) begin
                    bready_n    = 1'b0;
                    rsp_resp_n  = m_axi_bresp;
                    rsp_rdata_n = '0;
                    rsp_valid_n = 1'b1;
                    state_n     = IDLE;
                end
            end

            RDATA_WAIT: begin
                // rready only goes up once AR is done, so R cannot complete first.
                if (ar_hs) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                end
                if (r_hs) begin
                    rready_n    = 1'b0;
                    rsp_resp_n  = m_axi_rresp;
                    rsp_rdata_n = m_axi_rdata;
                    rsp_valid_n = 1'b1;
                    state_n     = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            rsp_valid     <= 1'b0;
            rsp_resp      <= AXI_OKAY;
            rsp_rdata     <= '0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            aw_done       <= aw_done_n;
            w_done        <= w_done_n;
            m_axi_awvalid <= awvalid_n;
            m_axi_wvalid  <= wvalid_n;
            m_axi_bready  <= bready_n;
            m_axi_arvalid <= arvalid_n;
            m_axi_rready  <= rready_n;
            m_axi_awaddr  <= awaddr_n;
            m_axi_araddr  <= araddr_n;
            m_axi_wdata   <= wdata_n;
            rsp_valid     <= rsp_valid_n;
            rsp_resp      <= rsp_resp_n;
            rsp_rdata     <= rsp_rdata_n;
            // Ready and busy follow the state being entered so they are flops too.
            cmd_ready     <= (state_n == IDLE);
            busy          <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_svm_axil_master.sv
// Bench for svm_axil_master: reactive AXI4-Lite slave model, response scoreboard.
module tb_svm_axil_master;
    import svm_axil_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, busy;
    logic [1:0]    rsp_resp;
    logic [DW-1:0] rsp_rdata;

    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]    m_axi_awprot, m_axi_arprot;
    logic          m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
    logic [DW-1:0] m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic          m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic [DW-1:0] m_axi_rdata = '0;

    always #5 clk = ~clk;

    svm_axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int passed = 0;
    int total  = 0;

    // Scoreboard entries are {resp, rdata}.
    logic [1+DW:0] sb[$];
    int            rsp_cnt = 0;

    // Slave configuration and bookkeeping.
    int            aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]    bresp_cfg = AXI_OKAY, rresp_cfg = AXI_OKAY;
    logic [DW-1:0] rdata_cfg = '0;
    int            aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit            aw_seen = 0, w_seen = 0, b_pend = 0, r_pend = 0, b_hs = 0, r_hs = 0;
    bit            slave_clr = 0;
    int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic [3:0]    last_wstrb = '0;

    // Slave model: acts at negedge; a handshake is recorded when the values it
    // leaves on the bus will be sampled high/high at the following posedge.
    initial forever begin
        @(negedge clk);
        if (slave_clr) begin
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0; b_hs = 0; r_hs = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            slave_clr = 0;
        end
        if (b_hs) begin m_axi_bvalid = 0; b_hs = 0; end
        if (r_hs) begin m_axi_rvalid = 0; r_hs = 0; end
        if (b_pend) begin m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; b_pend = 0; end
        if (r_pend) begin
            m_axi_rvalid = 1; m_axi_rresp = rresp_cfg; m_axi_rdata = rdata_cfg; r_pend = 0;
        end
        if (m_axi_awvalid) begin
            m_axi_awready = (aw_wait >= aw_delay);
            if (!m_axi_awready) aw_wait++;
        end else m_axi_awready = 0;
        if (m_axi_wvalid) begin
            m_axi_wready = (w_wait >= w_delay);
            if (!m_axi_wready) w_wait++;
        end else m_axi_wready = 0;
        if (m_axi_arvalid) begin
            m_axi_arready = (ar_wait >= ar_delay);
            if (!m_axi_arready) ar_wait++;
        end else m_axi_arready = 0;
        if (m_axi_awvalid && m_axi_awready) begin
            aw_cnt++; last_awaddr = m_axi_awaddr; aw_seen = 1; aw_wait = 0;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            w_cnt++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb; w_seen = 1; w_wait = 0;
        end
        if (aw_seen && w_seen) begin b_pend = 1; aw_seen = 0; w_seen = 0; end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_cnt++; last_araddr = m_axi_araddr; r_pend = 1; ar_wait = 0;
        end
        if (m_axi_bvalid && m_axi_bready) begin b_cnt++; b_hs = 1; end
        if (m_axi_rvalid && m_axi_rready) begin r_cnt++; r_hs = 1; end
    end

    // Response monitor: every strobe cycle must match the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            total++;
            if (sb.size() == 0) begin
                $display("FAIL rsp_unexpected: got resp=%b rdata=%h, required no response", rsp_resp, rsp_rdata);
            end else begin
                logic [1+DW:0] exp;
                exp = sb.pop_front();
                if ({rsp_resp, rsp_rdata} !== exp)
                    $display("FAIL rsp_payload: got resp=%b rdata=%h, required resp=%b rdata=%h",
                             rsp_resp, rsp_rdata, exp[DW+1:DW], exp[DW-1:0]);
                else passed++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a command until accepted; the expectation is queued at accept.
    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [1:0] er, input logic [DW-1:0] ed, input bit expect_rsp);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        total++;
        if (cmd_ready !== 1'b1) $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1", cmd_ready);
        else begin
            passed++;
            if (expect_rsp) sb.push_back({er, ed});
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    // Count negedges until the response strobe; -1 on timeout.
    task automatic wait_rsp(output int cyc);
        int n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid !== 1'b1 && n < 100);
        cyc = (rsp_valid === 1'b1) ? n : -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_ready, busy, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
             m_axi_rready, rsp_valid} !== 8'b1000_0000)
            $display("FAIL reset_ctrl: got ready/busy/aw/w/ar/b/r/rsp=%b, required 10000000",
                     {cmd_ready, busy, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                      m_axi_bready, m_axi_rready, rsp_valid});
        else passed++;
        total++;
        if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, rsp_resp, rsp_rdata} !== '0)
            $display("FAIL reset_data: got awaddr=%h araddr=%h wdata=%h resp=%b rdata=%h, required 0",
                     m_axi_awaddr, m_axi_araddr, m_axi_wdata, rsp_resp, rsp_rdata);
        else passed++;
        total++;
        if ({m_axi_wstrb, m_axi_awprot, m_axi_arprot} !== {4'hF, 6'b0})
            $display("FAIL fixed_attr: got wstrb=%h awprot=%b arprot=%b, required F/000/000",
                     m_axi_wstrb, m_axi_awprot, m_axi_arprot);
        else passed++;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        int c_aw = aw_cnt, c_w = w_cnt, cyc;
        send_cmd(1, 4'h4, 32'h0000_0001, AXI_OKAY, '0, 1);
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, busy, cmd_ready} !== 4'b1110)
            $display("FAIL wr_issue: got aw/w/busy/ready=%b, required 1110",
                     {m_axi_awvalid, m_axi_wvalid, busy, cmd_ready});
        else passed++;
        total++;
        if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== {4'h4, 32'h1, 4'hF})
            $display("FAIL wr_payload: got awaddr=%h wdata=%h wstrb=%h, required 4/00000001/F",
                     m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
        else passed++;
        wait_rsp(cyc);
        total++;
        if (cyc != 2) $display("FAIL wr_latency: rsp_valid %0d cycles after issue, required 2", cyc);
        else passed++;
        total++;
        if ({aw_cnt - c_aw, w_cnt - c_w} !== {32'd1, 32'd1} || last_awaddr !== 4'h4 ||
            last_wdata !== 32'h1 || last_wstrb !== 4'hF)
            $display("FAIL wr_beats: got aw=%0d w=%0d addr=%h data=%h strb=%h, required 1/1/4/1/F",
                     aw_cnt - c_aw, w_cnt - c_w, last_awaddr, last_wdata, last_wstrb);
        else passed++;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_pulse: rsp_valid=%b after pulse, required 0", rsp_valid);
        else passed++;
    endtask

    task automatic test_read_basic();
        int c_ar = ar_cnt, cyc;
        rresp_cfg = AXI_OKAY; rdata_cfg = 32'hDEAD_BEEF;
        send_cmd(0, 4'h8, '0, AXI_OKAY, 32'hDEAD_BEEF, 1);
        total++;
        if ({m_axi_arvalid, m_axi_rready, busy, m_axi_araddr} !== {3'b101, 4'h8})
            $display("FAIL rd_issue: got ar/rready/busy=%b araddr=%h, required 101/8",
                     {m_axi_arvalid, m_axi_rready, busy}, m_axi_araddr);
        else passed++;
        wait_rsp(cyc);
        total++;
        if (cyc != 2 || rsp_rdata !== 32'hDEAD_BEEF)
            $display("FAIL rd_latency: got %0d cycles rdata=%h, required 2/DEADBEEF", cyc, rsp_rdata);
        else passed++;
        total++;
        if (ar_cnt - c_ar != 1 || last_araddr !== 4'h8)
            $display("FAIL rd_beats: got ar=%0d addr=%h, required 1/8", ar_cnt - c_ar, last_araddr);
        else passed++;
    endtask

    task automatic test_aw_delay();
        int c_aw = aw_cnt, c_w = w_cnt, cyc;
        aw_delay = 3;
        send_cmd(1, 4'hC, 32'hA5A5_5A5A, AXI_OKAY, '0, 1);
        total++;
        if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11)
            $display("FAIL awd_c1: got aw/w=%b, required 11", {m_axi_awvalid, m_axi_wvalid});
        else passed++;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b100 || m_axi_awaddr !== 4'hC)
                $display("FAIL awd_hold c%0d: got aw/w/bready=%b awaddr=%h, required 100/C",
                         k, {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, m_axi_awaddr);
            else passed++;
        end
        @(negedge clk);
        total++;
        if ({m_axi_awvalid, m_axi_bready} !== 2'b01)
            $display("FAIL awd_c5: got aw/bready=%b, required 01", {m_axi_awvalid, m_axi_bready});
        else passed++;
        wait_rsp(cyc);
        total++;
        if (cyc != 1 || aw_cnt - c_aw != 1 || w_cnt - c_w != 1)
            $display("FAIL awd_done: got cyc=%0d aw=%0d w=%0d, required 1/1/1",
                     cyc, aw_cnt - c_aw, w_cnt - c_w);
        else passed++;
        aw_delay = 0;
    endtask

    task automatic test_slverr_back_to_back();
        int c_aw = aw_cnt, cyc;
        rresp_cfg = AXI_SLVERR; rdata_cfg = 32'h1234_5678; bresp_cfg = AXI_DECERR;
        send_cmd(0, 4'h0, '0, AXI_SLVERR, 32'h1234_5678, 1);
        // Offered while busy: must wait, then be taken on the response cycle.
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h8; cmd_wdata = 32'hCAFE_F00D;
        wait_rsp(cyc);
        total++;
        if (cyc != 2 || cmd_ready !== 1'b1 || rsp_resp !== AXI_SLVERR)
            $display("FAIL b2b_rsp: got cyc=%0d cmd_ready=%b resp=%b, required 2/1/10",
                     cyc, cmd_ready, rsp_resp);
        else passed++;
        sb.push_back({AXI_DECERR, 32'h0});
        @(negedge clk);
        cmd_valid = 0;
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, busy} !== 3'b111 || m_axi_awaddr !== 4'h8)
            $display("FAIL b2b_accept: got aw/w/busy=%b awaddr=%h, required 111/8",
                     {m_axi_awvalid, m_axi_wvalid, busy}, m_axi_awaddr);
        else passed++;
        wait_rsp(cyc);
        total++;
        if (cyc != 2 || rsp_resp !== AXI_DECERR || rsp_rdata !== 32'h0 || aw_cnt - c_aw != 1)
            $display("FAIL b2b_write: got cyc=%0d resp=%b rdata=%h aw=%0d, required 2/11/0/1",
                     cyc, rsp_resp, rsp_rdata, aw_cnt - c_aw);
        else passed++;
        rresp_cfg = AXI_OKAY; bresp_cfg = AXI_OKAY;
    endtask

    task automatic test_busy_hold();
        int c_ar = ar_cnt, c_rsp = rsp_cnt, cyc;
        ar_delay = 2; rdata_cfg = 32'h0BAD_F00D;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'hC;
        total++;
        if (cmd_ready !== 1'b1) $display("FAIL hold_ready: cmd_ready=%b, required 1", cmd_ready);
        else begin passed++; sb.push_back({AXI_OKAY, 32'h0BAD_F00D}); end
        wait_rsp(cyc);
        cmd_valid = 0;
        total++;
        if (cyc != 5) $display("FAIL hold_latency: got %0d cycles, required 5", cyc);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (ar_cnt - c_ar != 1 || rsp_cnt - c_rsp != 1 || busy !== 1'b0)
            $display("FAIL hold_single: got ar=%0d rsp=%0d busy=%b, required 1/1/0",
                     ar_cnt - c_ar, rsp_cnt - c_rsp, busy);
        else passed++;
        ar_delay = 0;
    endtask

    task automatic test_reset_mid();
        int c_ar = ar_cnt, c_rsp = rsp_cnt;
        ar_delay = 5;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h4;
        @(negedge clk);
        cmd_valid = 0;
        total++;
        if (m_axi_arvalid !== 1'b1) $display("FAIL rstmid_pending: arvalid=%b, required 1", m_axi_arvalid);
        else passed++;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        slave_clr = 1;
        total++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
             rsp_valid, busy, cmd_ready} !== 8'b0000_0001)
            $display("FAIL rstmid_state: got aw/w/ar/b/r/rsp/busy/ready=%b, required 00000001",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                      rsp_valid, busy, cmd_ready});
        else passed++;
        repeat (8) @(negedge clk);
        total++;
        if (ar_cnt - c_ar != 0 || rsp_cnt - c_rsp != 0)
            $display("FAIL rstmid_abandon: got ar=%0d rsp=%0d, required 0/0", ar_cnt - c_ar, rsp_cnt - c_rsp);
        else passed++;
        ar_delay = 0;
    endtask

    task automatic test_after_reset();
        int cyc;
        rdata_cfg = 32'h600D_0001;
        send_cmd(0, 4'h4, '0, AXI_OKAY, 32'h600D_0001, 1);
        wait_rsp(cyc);
        total++;
        if (cyc != 2 || last_araddr !== 4'h4)
            $display("FAIL recover_read: got cyc=%0d araddr=%h, required 2/4", cyc, last_araddr);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_aw_delay();
        test_slverr_back_to_back();
        test_busy_hold();
        test_reset_mid();
        test_after_reset();
        repeat (5) @(negedge clk);
        total++;
        if (sb.size() != 0) $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
